simple_mips_cpu: RTL and testbench

- Single-cycle 16-bit simplified MIPS core. Fetches one 16-bit instruction per clock from an internal, preloaded program ROM.
- Executes R-type ALU ops and ADDI against a 4-entry register file.
- Exposes PC, the current instruction (IR) and the ALU result (ALUOut) for observation.
- Top-level processor block; no external memory or bus interfaces.

---
 rtl/simple_mips_cpu_pkg.sv | 42 ++++
 rtl/simple_mips_cpu_alu.sv | 25 ++
 rtl/simple_mips_cpu.sv | 82 ++++++++
 tb/tb_simple_mips_cpu.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/simple_mips_cpu_pkg.sv
// Shared constants for the 16-bit single-cycle MIPS core: opcodes, ALU codes,
// instruction field positions and the default program image.
package simple_mips_cpu_pkg;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 10;
  localparam int RT_MSB  = 9;
  localparam int RT_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b0111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // 64-word image, word i at bits [16*i +: 16]; unused words are ADD $0,$0,$0.
  localparam logic [1023:0] DEFAULT_ROM = {
    {54{16'h0000}},
    16'hFFFF, 16'h6B40, 16'h6E40, 16'h4B40, 16'h0BC0,
    16'h3B80, 16'h1780, 16'h26C0, 16'h7207, 16'h710F
  };

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/simple_mips_cpu_alu.sv
// 16-bit ALU selected by a 4-bit control code; results wrap, no flags.
// Unknown control codes fall back to AND so no-op instructions still drive a value.
module alu16
  import simple_mips_cpu_pkg::*;
(
  input  logic [3:0]  ctrl_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] y_o
);

  always_comb begin
    y_o = a_i & b_i;
    case (ctrl_i)
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_SLT: y_o = {15'd0, ($signed(a_i) < $signed(b_i))};
      ALU_NOR: y_o = ~(a_i | b_i);
      default: y_o = a_i & b_i;
    endcase
  end

endmodule

// File: rtl/simple_mips_cpu.sv
// Single-cycle 16-bit MIPS core: ROM fetch, decode, 4-entry register file, ALU.
// State (PC, registers) updates on the falling clock edge; reset is asynchronous.
module simple_mips_cpu
  import simple_mips_cpu_pkg::*;
#(
  parameter int                         ROM_WORDS = 64,
  parameter logic [ROM_WORDS*16-1:0]    ROM_IMAGE = DEFAULT_ROM[ROM_WORDS*16-1:0]
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] PC,
  output logic [15:0] IR,
  output logic [15:0] ALUOut
);

  localparam int AW = $clog2(ROM_WORDS);

  logic [15:0]   pc_q, pc_d;
  logic [15:0]   rf_q [0:3];
  logic [AW-1:0] rom_idx;
  logic [3:0]    op;
  logic [1:0]    rs, rt, rd, wr_idx;
  logic [15:0]   rs_val, rt_val, alu_b;
  logic [3:0]    alu_ctrl;
  logic          wr_en;
  logic          use_imm;

  assign rom_idx = pc_q[AW:1];
  assign IR      = ROM_IMAGE[{rom_idx, 4'b0000} +: 16];
  assign PC      = pc_q;
  assign pc_d    = pc_q + 16'd2;

  assign op = IR[OP_MSB:OP_LSB];
  assign rs = IR[RS_MSB:RS_LSB];
  assign rt = IR[RT_MSB:RT_LSB];
  assign rd = IR[RD_MSB:RD_LSB];

  // Register 0 is hardwired to zero on the read side.
  assign rs_val = (rs == 2'd0) ? 16'd0 : rf_q[rs];
  assign rt_val = (rt == 2'd0) ? 16'd0 : rf_q[rt];
  assign alu_b  = use_imm ? sext8(IR[IMM_MSB:IMM_LSB]) : rt_val;

  always_comb begin
    alu_ctrl = ALU_AND;
    wr_en    = 1'b0;
    wr_idx   = rd;
    use_imm  = 1'b0;
    case (op)
      OP_ADD:  begin alu_ctrl = ALU_ADD; wr_en = 1'b1; end
      OP_SUB:  begin alu_ctrl = ALU_SUB; wr_en = 1'b1; end
      OP_AND:  begin alu_ctrl = ALU_AND; wr_en = 1'b1; end
      OP_OR:   begin alu_ctrl = ALU_OR;  wr_en = 1'b1; end
      OP_NOR:  begin alu_ctrl = ALU_NOR; wr_en = 1'b1; end
      OP_SLT:  begin alu_ctrl = ALU_SLT; wr_en = 1'b1; end
      OP_ADDI: begin
        alu_ctrl = ALU_ADD;
        wr_en    = 1'b1;
        wr_idx   = rt;
        use_imm  = 1'b1;
      end
      default: ;
    endcase
  end

  alu16 u_alu (
    .ctrl_i (alu_ctrl),
    .a_i    (rs_val),
    .b_i    (alu_b),
    .y_o    (ALUOut)
  );

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= 16'd0;
      for (int i = 0; i < 4; i++) rf_q[i] <= 16'd0;
    end else begin
      pc_q <= pc_d;
      if (wr_en && (wr_idx != 2'd0)) rf_q[wr_idx] <= ALUOut;
    end
  end

endmodule

// File: tb/tb_simple_mips_cpu.sv
// Scoreboard bench: expected PC/IR/ALUOut per cycle queued, compared on the rising edge.
module tb_simple_mips_cpu;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] alu;
  } exp_t;

  localparam logic [1023:0] ALT_ROM = {
    {58{16'h0000}},
    16'h00C0, 16'h7405, 16'h0480, 16'hF5FF, 16'h0540, 16'h71FF
  };

  logic        clock;
  logic        reset;
  logic [15:0] pc_m, ir_m, alu_m;
  logic [15:0] pc_a, ir_a, alu_a;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q_main[$];
  exp_t q_alt[$];

  simple_mips_cpu u_dut (
    .clock  (clock),
    .reset  (reset),
    .PC     (pc_m),
    .IR     (ir_m),
    .ALUOut (alu_m)
  );

  simple_mips_cpu #(.ROM_WORDS(64), .ROM_IMAGE(ALT_ROM)) u_alt (
    .clock  (clock),
    .reset  (reset),
    .PC     (pc_a),
    .IR     (ir_a),
    .ALUOut (alu_a)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic push_m(input logic [15:0] pc, input logic [15:0] ir, input logic [15:0] alu);
    exp_t e;
    e.pc = pc; e.ir = ir; e.alu = alu;
    q_main.push_back(e);
  endtask

  task automatic push_a(input logic [15:0] pc, input logic [15:0] ir, input logic [15:0] alu);
    exp_t e;
    e.pc = pc; e.ir = ir; e.alu = alu;
    q_alt.push_back(e);
  endtask

  // First comparison is taken immediately (before the first falling edge).
  task automatic run_sb();
    exp_t e;
    bit   first = 1'b1;
    int   guard = 0;
    while ((q_main.size() != 0 || q_alt.size() != 0) && guard < 1000) begin
      if (!first) begin
        @(posedge clock);
        #1;
      end
      first = 1'b0;
      guard++;
      if (q_main.size() != 0) begin
        e = q_main.pop_front();
        chk($sformatf("main_pc@%0d", e.pc),  pc_m,  e.pc);
        chk($sformatf("main_ir@%0d", e.pc),  ir_m,  e.ir);
        chk($sformatf("main_alu@%0d", e.pc), alu_m, e.alu);
      end
      if (q_alt.size() != 0) begin
        e = q_alt.pop_front();
        chk($sformatf("alt_pc@%0d", e.pc),  pc_a,  e.pc);
        chk($sformatf("alt_ir@%0d", e.pc),  ir_a,  e.ir);
        chk($sformatf("alt_alu@%0d", e.pc), alu_a, e.alu);
      end
    end
  endtask

  task automatic push_main_program();
    push_m(16'd0,  16'h710F, 16'd15);
    push_m(16'd2,  16'h7207, 16'd7);
    push_m(16'd4,  16'h26C0, 16'd7);
    push_m(16'd6,  16'h1780, 16'd8);
    push_m(16'd8,  16'h3B80, 16'd15);
    push_m(16'd10, 16'h0BC0, 16'd22);
    push_m(16'd12, 16'h4B40, 16'hFFE0);
    push_m(16'd14, 16'h6E40, 16'd0);
    push_m(16'd16, 16'h6B40, 16'd1);
    push_m(16'd18, 16'hFFFF, 16'd22);
    for (int p = 20; p <= 30; p += 2) push_m(16'(p), 16'h0000, 16'h0000);
  endtask

  task automatic push_alt_program();
    push_a(16'd0,  16'h71FF, 16'hFFFF);
    push_a(16'd2,  16'h0540, 16'hFFFE);
    push_a(16'd4,  16'hF5FF, 16'hFFFE);
    push_a(16'd6,  16'h0480, 16'hFFFE);
    push_a(16'd8,  16'h7405, 16'h0003);
    push_a(16'd10, 16'h00C0, 16'h0000);
    push_a(16'd12, 16'h0000, 16'h0000);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_pc",     pc_m,  16'd0);
    chk("rst_ir",     ir_m,  16'h710F);
    chk("rst_alu",    alu_m, 16'd15);
    chk("rst_alt_pc", pc_a,  16'd0);

    // Short run up to PC=8, then reset asynchronously mid-cycle.
    push_m(16'd0, 16'h710F, 16'd15);
    push_m(16'd2, 16'h7207, 16'd7);
    push_m(16'd4, 16'h26C0, 16'd7);
    push_m(16'd6, 16'h1780, 16'd8);
    push_m(16'd8, 16'h3B80, 16'd15);
    @(posedge clock);
    reset = 1'b0;
    #1;
    run_sb();

    reset = 1'b1;
    #1;
    chk("async_rst_pc",     pc_m,  16'd0);
    chk("async_rst_alu",    alu_m, 16'd15);
    chk("async_rst_alt_pc", pc_a,  16'd0);

    push_main_program();
    push_alt_program();
    @(posedge clock);
    reset = 1'b0;
    #1;
    run_sb();
    chk("sb_drained", 16'(q_main.size() + q_alt.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
